// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Registered ALU operands; the captured result returns on a valid/ready channel tagged with the requester id.
module alu_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*4-1:0]      req_op,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   output logic [3:0]                alu_op,
   input  logic [DATA_W-1:0]         alu_result,
   input  logic                      alu_zero,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_result,
   output logic                      rsp_zero,
   output logic                      rsp_err,
   output logic                      busy
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     last_grant_q, last_grant_d;
   logic [DATA_W-1:0]   alu_a_q, alu_a_d;
   logic [DATA_W-1:0]   alu_b_q, alu_b_d;
   logic [3:0]          alu_op_q, alu_op_d;
   logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
   logic                rsp_zero_q, rsp_zero_d;
   logic                rsp_err_q, rsp_err_d;

   logic                grant_found;
   logic [ID_W-1:0]     grant_id;
   logic [ID_W-1:0]     cand;

   // Scan from farthest to nearest so the requester right after last_grant wins.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      cand        = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
         if (req_valid[cand]) begin
            grant_found = 1'b1;
            grant_id    = cand;
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      req_ready    = '0;
      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               // Qualified by rst_n so no handshake is reported while reset is held.
               req_ready[grant_id] = rst_n;
               alu_a_d      = req_a[int'(grant_id)*DATA_W +: DATA_W];
               alu_b_d      = req_b[int'(grant_id)*DATA_W +: DATA_W];
               alu_op_d     = req_op[int'(grant_id)*4 +: 4];
               last_grant_d = grant_id;
               state_d      = S_EXEC;
            end
         end
         S_EXEC: begin
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            rsp_err_d    = (alu_op_q > 4'b1001);
            rsp_id_d     = last_grant_q;
            state_d      = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to its alu_* ports.
// Opcode map of the ALU model: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
module tb_alu_share_arbiter;
   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 32;
   localparam int ID_W    = 2;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_a;
   logic [NUM_REQ*DATA_W-1:0] req_b;
   logic [NUM_REQ*4-1:0]      req_op;
   logic [DATA_W-1:0]         alu_a, alu_b, alu_result;
   logic [3:0]                alu_op;
   logic                      alu_zero;
   logic                      rsp_valid, rsp_ready, rsp_zero, rsp_err, busy;
   logic [ID_W-1:0]           rsp_id;
   logic [DATA_W-1:0]         rsp_result;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .busy(busy)
   );

   always_comb begin
      alu_result = '0;
      case (alu_op)
         4'd0: alu_result = alu_a + alu_b;
         4'd1: alu_result = alu_a - alu_b;
         4'd2: alu_result = alu_a & alu_b;
         4'd3: alu_result = alu_a | alu_b;
         4'd4: alu_result = alu_a ^ alu_b;
         4'd5: alu_result = alu_a << alu_b[4:0];
         4'd6: alu_result = alu_a >> alu_b[4:0];
         4'd7: alu_result = DATA_W'($signed(alu_a) >>> alu_b[4:0]);
         4'd8: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         4'd9: alu_result = {31'd0, alu_a < alu_b};
         default: alu_result = '0;
      endcase
   end
   assign alu_zero = (alu_result == '0);

   typedef struct {
      int          r;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] res;
      logic        zero;
      logic        err;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      req_a[r*DATA_W +: DATA_W] = a;
      req_b[r*DATA_W +: DATA_W] = b;
      req_op[r*4 +: 4]          = op;
   endtask

   // Presents one request and returns at the start of its EXEC cycle.
   task automatic issue(input string name, input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
      logic got = 1'b0;
      set_req(r, a, b, op);
      req_valid[r] = 1'b1;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (req_ready[r]) got = 1'b1;
         else tick();
      end
      check({name, "_granted"}, 64'(got), 64'd1);
      if (got) check({name, "_ready"}, 64'(req_ready), 64'(4'b1 << r));
      tick();
      req_valid[r] = 1'b0;
   endtask

   task automatic wait_rsp(input string name, input int id, input logic [31:0] res,
                           input logic zero, input logic err);
      logic got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (rsp_valid) got = 1'b1;
         else tick();
      end
      check({name, "_rsp_seen"}, 64'(got), 64'd1);
      if (got) begin
         check({name, "_id"}, 64'(rsp_id), 64'(id));
         check({name, "_result"}, 64'(rsp_result), 64'(res));
         check({name, "_zero"}, 64'(rsp_zero), 64'(zero));
         check({name, "_err"}, 64'(rsp_err), 64'(err));
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int gi[$];
      int gc[$];

      vecs[0] = '{r: 0, a: 32'd5,        b: 32'd3,        op: 4'd0,    res: 32'd8,          zero: 1'b0, err: 1'b0};
      vecs[1] = '{r: 1, a: 32'd7,        b: 32'd7,        op: 4'd1,    res: 32'd0,          zero: 1'b1, err: 1'b0};
      vecs[2] = '{r: 2, a: 32'h80000000, b: 32'd4,        op: 4'd7,    res: 32'hF8000000,   zero: 1'b0, err: 1'b0};
      vecs[3] = '{r: 3, a: 32'hFFFFFFFF, b: 32'd1,        op: 4'd8,    res: 32'd1,          zero: 1'b0, err: 1'b0};
      vecs[4] = '{r: 0, a: 32'd9,        b: 32'd9,        op: 4'hF,    res: 32'd0,          zero: 1'b1, err: 1'b1};
      vecs[5] = '{r: 1, a: 32'h0000FF0F, b: 32'h00000FF0, op: 4'd2,    res: 32'h00000F00,   zero: 1'b0, err: 1'b0};
      vecs[6] = '{r: 2, a: 32'hFFFFFFFF, b: 32'd1,        op: 4'b1001, res: 32'd0,          zero: 1'b1, err: 1'b0};
      vecs[7] = '{r: 3, a: 32'd1,        b: 32'd2,        op: 4'b1010, res: 32'd0,          zero: 1'b1, err: 1'b1};

      req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
      req_valid = 4'b1111;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_req_ready", 64'(req_ready), 64'd0);
      check("reset_alu_a", 64'(alu_a), 64'd0);
      check("reset_alu_op", 64'(alu_op), 64'd0);
      check("reset_rsp_result", 64'(rsp_result), 64'd0);
      req_valid = '0;
      rst_n = 1'b1;
      tick();

      // Single transaction with cycle-exact latency.
      set_req(0, 32'd5, 32'd3, 4'd0);
      req_valid = 4'b0001;
      @(negedge clk);
      check("single_ready", 64'(req_ready), 64'b0001);
      check("single_idle_busy", 64'(busy), 64'd0);
      tick();
      req_valid = '0;
      @(negedge clk);
      check("single_exec_ready", 64'(req_ready), 64'd0);
      check("single_exec_busy", 64'(busy), 64'd1);
      check("single_exec_valid", 64'(rsp_valid), 64'd0);
      check("single_alu_a", 64'(alu_a), 64'd5);
      check("single_alu_b", 64'(alu_b), 64'd3);
      tick();
      @(negedge clk);
      check("single_rsp_valid", 64'(rsp_valid), 64'd1);
      check("single_rsp_id", 64'(rsp_id), 64'd0);
      check("single_rsp_result", 64'(rsp_result), 64'd8);
      check("single_rsp_zero", 64'(rsp_zero), 64'd0);
      check("single_rsp_err", 64'(rsp_err), 64'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      @(negedge clk);
      check("single_done_valid", 64'(rsp_valid), 64'd0);
      check("single_done_busy", 64'(busy), 64'd0);
      tick();

      // Table of operations.
      for (int i = 0; i < 8; i++) begin
         issue($sformatf("vec%0d", i), vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op);
         wait_rsp($sformatf("vec%0d", i), vecs[i].r, vecs[i].res, vecs[i].zero, vecs[i].err);
      end

      // Round robin with everyone valid and the consumer always ready.
      do_reset();
      for (int r = 0; r < NUM_REQ; r++) set_req(r, 32'(r), 32'd1, 4'd0);
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         for (int r = 0; r < NUM_REQ; r++) begin
            if (req_ready[r]) begin
               gi.push_back(r);
               gc.push_back(c);
            end
         end
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b0;
      check("rr_grant_count", 64'(gi.size()), 64'd5);
      for (int k = 0; k < 5 && k < gi.size(); k++) begin
         check($sformatf("rr_grant%0d_id", k), 64'(gi[k]), 64'(k % NUM_REQ));
         check($sformatf("rr_grant%0d_cycle", k), 64'(gc[k]), 64'(3 * k));
      end
      tick();
      tick();

      // Backpressure: response held while the consumer stalls.
      issue("bp", 2, 32'd10, 32'd20, 4'd0);
      req_valid = 4'b1011;
      tick();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("bp%0d_valid", c), 64'(rsp_valid), 64'd1);
         check($sformatf("bp%0d_result", c), 64'(rsp_result), 64'd30);
         check($sformatf("bp%0d_id", c), 64'(rsp_id), 64'd2);
         check($sformatf("bp%0d_ready", c), 64'(req_ready), 64'd0);
         check($sformatf("bp%0d_alu_a", c), 64'(alu_a), 64'd10);
         tick();
      end
      rsp_ready = 1'b1;
      req_valid = '0;
      tick();
      rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_release_valid", 64'(rsp_valid), 64'd0);
      check("bp_release_busy", 64'(busy), 64'd0);
      tick();

      // Pointer wrap: last_grant=2, then 0101 grants 0, then 2.
      do_reset();
      issue("ptr_setup", 2, 32'd1, 32'd1, 4'd0);
      wait_rsp("ptr_setup", 2, 32'd2, 1'b0, 1'b0);
      set_req(0, 32'd3, 32'd4, 4'd0);
      set_req(2, 32'd6, 32'd6, 4'd4);
      req_valid = 4'b0101;
      @(negedge clk);
      check("ptr_wrap_grant0", 64'(req_ready), 64'b0001);
      tick();
      req_valid = 4'b0100;
      wait_rsp("ptr_r0", 0, 32'd7, 1'b0, 1'b0);
      req_valid = 4'b0101;
      @(negedge clk);
      check("ptr_next_grant2", 64'(req_ready), 64'b0100);
      tick();
      req_valid = 4'b0001;
      wait_rsp("ptr_r2", 2, 32'd0, 1'b1, 1'b0);
      req_valid = '0;
      tick();
      tick();
      tick();

      // Reset during EXEC drops everything; requester 0 wins first afterwards.
      issue("rst_mid", 1, 32'd7, 32'd9, 4'd0);
      set_req(0, 32'd4, 32'd4, 4'd1);
      req_valid = 4'b1111;
      check("rst_mid_busy_before", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_alu_a", 64'(alu_a), 64'd0);
      check("rst_mid_alu_b", 64'(alu_b), 64'd0);
      check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_mid_req_ready", 64'(req_ready), 64'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_after_grant0", 64'(req_ready), 64'b0001);
      tick();
      req_valid = '0;
      wait_rsp("rst_after", 0, 32'd0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
